// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the inverse-cipher round sequencer.
// Holds the FSM state type, the key-size encodings and the Nr lookup.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] MODE_128     = 2'b00;
  localparam logic [1:0] MODE_192     = 2'b01;
  localparam logic [1:0] MODE_256     = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  // Number of rounds for a legal key size; the illegal code never reaches RUN.
  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      MODE_192: nr_of = 4'd12;
      MODE_256: nr_of = 4'd14;
      default:  nr_of = 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_beat_counter.sv
// Per-round beat counter: counts 0..ROUND_CYCLES-1 while enabled and
// pulses tc_o on the last beat, returning to 0 on that same edge.
module aes_beat_counter #(
  parameter int ROUND_CYCLES = 20,
  parameter int CYC_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CYC_W-1:0] cyc_o,
  output logic             tc_o
);

  localparam logic [CYC_W-1:0] LAST_BEAT = CYC_W'(ROUND_CYCLES - 1);

  logic [CYC_W-1:0] cyc_q, cyc_d;

  assign tc_o  = enable_i && (cyc_q == LAST_BEAT);
  assign cyc_o = cyc_q;

  // NOTE: cyc_d takes its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    cyc_d = cyc_q;
    if (clear_i || tc_o) begin
      cyc_d = '0;
    end else if (enable_i) begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  // NOTE: registers update with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Sequencer for the radix-8 inverse round datapath: latches a ciphertext,
// steps Nr rounds fetching keys Nr..1, runs the final add-round-key, returns pt.
module aes_inv_round_ctrl #(
  parameter int ROUND_CYCLES = 20,
  parameter int CYC_W        = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct_i,
  input  logic [1:0]   mode_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_o,
  output logic         err_o,
  output logic         busy_o,
  output logic [3:0]   key_idx_o,
  input  logic [127:0] key_i,
  output logic [3:0]   dp_round,
  output logic [1:0]   dp_mode,
  output logic [3:0]   dp_width_sel,
  output logic [127:0] dp_data_in,
  output logic [127:0] dp_round_key,
  input  logic [127:0] dp_data_out
);
  import aes_ctrl_pkg::*;

  if (ROUND_CYCLES < 16) begin : g_round_cycles_check
    $error("aes_inv_round_ctrl: ROUND_CYCLES must be at least 16");
  end
  if ((2 ** CYC_W) < ROUND_CYCLES) begin : g_cyc_w_check
    $error("aes_inv_round_ctrl: CYC_W too narrow for ROUND_CYCLES");
  end

  ctrl_state_e      state_q, state_d;
  logic [3:0]       round_q;
  logic [1:0]       mode_q;
  logic [127:0]     data_q;
  logic [127:0]     pt_q;
  logic             err_q, err_d;
  logic             accept;
  logic             tc;
  logic [CYC_W-1:0] cyc;
  logic [3:0]       nr;

  assign nr = nr_of(mode_q);

  aes_beat_counter #(
    .ROUND_CYCLES(ROUND_CYCLES),
    .CYC_W       (CYC_W)
  ) u_beat (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept),
    .enable_i(state_q == RUN),
    .cyc_o   (cyc),
    .tc_o    (tc)
  );

  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    err_d        = 1'b0;
    accept       = 1'b0;
    dp_round     = 4'd0;
    dp_width_sel = 4'd0;
    key_idx_o    = 4'd0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (mode_i == MODE_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        dp_round     = round_q;
        // Wraps modulo 16 when a round is longer than 16 beats.
        dp_width_sel = 4'(cyc);
        key_idx_o    = nr - round_q;
        if (tc && ((round_q + 4'd1) == nr)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        dp_round = nr;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the wide data registers are reset as well because pt_o and the state register have defined reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      mode_q  <= MODE_128;
      data_q  <= '0;
      pt_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        data_q  <= ct_i;
        mode_q  <= mode_i;
        round_q <= 4'd0;
      end else if ((state_q == RUN) && tc) begin
        data_q  <= dp_data_out;
        round_q <= round_q + 4'd1;
      end
      if (state_q == FINAL) begin
        pt_q <= dp_data_out;
      end
    end
  end

  assign out_valid    = (state_q == DONE);
  assign busy_o       = (state_q == RUN) || (state_q == FINAL);
  assign pt_o         = pt_q;
  assign err_o        = err_q;
  assign dp_mode      = mode_q;
  assign dp_data_in   = data_q;
  assign dp_round_key = key_i;

endmodule
